// File: rtl/alu_seq_pkg.sv
// Shared types and opcode constants for the ALU sequencer.
// Opcode values double as bit positions in the one-hot ALU control word.
package alu_seq_pkg;

  localparam int unsigned SIG_COUNT = 12;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StDone
  } state_e;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_DIV  = 4'd3;
  localparam logic [3:0] OP_SHR  = 4'd4;
  localparam logic [3:0] OP_SHL  = 4'd5;
  localparam logic [3:0] OP_ROR  = 4'd6;
  localparam logic [3:0] OP_ROL  = 4'd7;
  localparam logic [3:0] OP_AND  = 4'd8;
  localparam logic [3:0] OP_OR   = 4'd9;
  localparam logic [3:0] OP_NEG  = 4'd10;
  localparam logic [3:0] OP_NOT  = 4'd11;
  localparam logic [3:0] OP_LAST = 4'd11;

  function automatic logic is_muldiv(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_sequencer_decode.sv
// Binary opcode index to one-hot ALU control; out-of-range indices decode to zero.
module op_onehot_decode #(
  parameter int unsigned SIG_COUNT = alu_seq_pkg::SIG_COUNT
) (
  input  logic [3:0]           idx,
  output logic [SIG_COUNT-1:0] onehot
);
  import alu_seq_pkg::*;

  always_comb begin
    onehot = '0;
    for (int unsigned i = 0; i < SIG_COUNT; i++) begin
      if ((idx <= OP_LAST) && (32'(idx) == i)) begin
        onehot[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// Request/response sequencer around an external combinational ALU.
// Legal requests spend 1 (or MULDIV_CYCLES) cycles in EXEC; illegal ones go straight to DONE.
module alu_sequencer #(
  parameter int unsigned BITS          = 32,
  parameter int unsigned SIG_COUNT     = alu_seq_pkg::SIG_COUNT,
  parameter int unsigned MULDIV_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [3:0]           opcode,
  input  logic [BITS-1:0]      a_in,
  input  logic [BITS-1:0]      b_in,
  output logic [SIG_COUNT-1:0] alu_ctrl,
  output logic [BITS-1:0]      alu_x,
  output logic [BITS-1:0]      alu_y,
  input  logic [BITS-1:0]      alu_hi,
  input  logic [BITS-1:0]      alu_lo,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [BITS-1:0]      rsp_hi,
  output logic [BITS-1:0]      rsp_lo,
  output logic                 rsp_err
);
  import alu_seq_pkg::*;

  // Counter holds remaining EXEC cycles minus one.
  localparam logic [3:0] MdLast = 4'(MULDIV_CYCLES - 1);

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [3:0]          op_q, op_d;
  logic [BITS-1:0]     x_q, x_d, y_q, y_d;
  logic [BITS-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic                err_q, err_d;
  logic                illegal;
  logic [SIG_COUNT-1:0] dec_ctrl;

  op_onehot_decode #(
    .SIG_COUNT(SIG_COUNT)
  ) u_decode (
    .idx   (op_q),
    .onehot(dec_ctrl)
  );

  assign illegal = (opcode > OP_LAST) || ((opcode == OP_DIV) && (b_in == '0));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    x_d     = x_q;
    y_d     = y_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    err_d   = err_q;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          op_d = opcode;
          x_d  = a_in;
          y_d  = b_in;
          if (illegal) begin
            state_d = StDone;
            cnt_d   = '0;
            hi_d    = '0;
            lo_d    = '0;
            err_d   = 1'b1;
          end else begin
            state_d = StExec;
            cnt_d   = is_muldiv(opcode) ? MdLast : 4'd0;
            err_d   = 1'b0;
          end
        end
      end
      StExec: begin
        if (cnt_q == 4'd0) begin
          state_d = StDone;
          lo_d    = alu_lo;
          // The ALU only drives HI for multiply and divide.
          hi_d    = is_muldiv(op_q) ? alu_hi : '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StDone: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      x_q     <= x_d;
      y_q     <= y_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      err_q   <= err_d;
    end
  end

  assign req_ready = (state_q == StIdle);
  assign rsp_valid = (state_q == StDone);
  assign alu_ctrl  = (state_q == StExec) ? dec_ctrl : '0;
  assign alu_x     = x_q;
  assign alu_y     = y_q;
  assign rsp_hi    = hi_q;
  assign rsp_lo    = lo_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: stimulus pushes expected responses,
// a negedge monitor checks latency, EXEC length, control word and response data.
module tb_alu_sequencer;
  localparam int W  = 32;
  localparam int SC = 12;
  localparam int MD = 4;

  typedef struct {
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;
    logic          err;
    int            k;
    logic [SC-1:0] ctrl;
  } exp_t;

  logic          clk = 1'b0;
  logic          clr = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [3:0]    opcode = '0;
  logic [W-1:0]  a_in = '0;
  logic [W-1:0]  b_in = '0;
  logic [SC-1:0] alu_ctrl;
  logic [W-1:0]  alu_x, alu_y, alu_hi, alu_lo;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [W-1:0]  rsp_hi, rsp_lo;
  logic          rsp_err;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   rdy_mode = 1;  // 0 random, 1 high, 2 low
  exp_t sb[$];

  alu_sequencer #(
    .BITS(W),
    .SIG_COUNT(SC),
    .MULDIV_CYCLES(MD)
  ) dut (
    .clk(clk), .clr(clr), .req_valid(req_valid), .req_ready(req_ready),
    .opcode(opcode), .a_in(a_in), .b_in(b_in), .alu_ctrl(alu_ctrl),
    .alu_x(alu_x), .alu_y(alu_y), .alu_hi(alu_hi), .alu_lo(alu_lo),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hi(rsp_hi),
    .rsp_lo(rsp_lo), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural ALU: {hi, lo} result for each operation.
  function automatic logic [2*W-1:0] alu_fn(input int op, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [2*W-1:0] p;
    logic [2*W-1:0] t;
    int s;
    s = int'(y % W);
    p = '0;
    t = {x, x};
    case (op)
      0:  p[W-1:0] = x + y;
      1:  p[W-1:0] = x - y;
      2:  p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
      3:  p = (y == '0) ? '0 : {x % y, x / y};
      4:  p[W-1:0] = x >> s;
      5:  p[W-1:0] = x << s;
      6:  begin t = t >> s; p[W-1:0] = t[W-1:0]; end
      7:  begin t = t << s; p[W-1:0] = t[2*W-1:W]; end
      8:  p[W-1:0] = x & y;
      9:  p[W-1:0] = x | y;
      10: p[W-1:0] = -x;
      11: p[W-1:0] = ~x;
      default: p = '0;
    endcase
    return p;
  endfunction

  function automatic exp_t ref_model(input int op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    logic [2*W-1:0] p;
    e.ctrl = '0;
    if (op > 11 || (op == 3 && b == '0)) begin
      e.hi = '0; e.lo = '0; e.err = 1'b1; e.k = 0;
    end else begin
      p = alu_fn(op, a, b);
      e.lo = p[W-1:0];
      e.hi = (op == 2 || op == 3) ? p[2*W-1:W] : '0;
      e.err = 1'b0;
      e.k = (op == 2 || op == 3) ? MD : 1;
      e.ctrl[op] = 1'b1;
    end
    return e;
  endfunction

  // Model ALU; HI carries junk for single-word ops so a missing zero-fill shows up.
  int alu_op;
  logic [2*W-1:0] alu_p;
  always_comb begin
    alu_op = -1;
    alu_p  = '0;
    for (int i = 0; i < SC; i++) if (alu_ctrl[i]) alu_op = i;
    if (alu_op >= 0) alu_p = alu_fn(alu_op, alu_x, alu_y);
    else alu_p[W-1:0] = 32'hDEAD_BEEF;
    alu_lo = alu_p[W-1:0];
    alu_hi = (alu_op == 2 || alu_op == 3) ? alu_p[2*W-1:W] : (alu_p[W-1:0] ^ 32'hA5A5_5A5A);
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rdy_mode == 0) rsp_ready = 1'($urandom_range(0, 1));
      else rsp_ready = (rdy_mode == 1);
    end
  end

  // Monitor
  initial begin
    int exec_n = 0;
    logic [SC-1:0] ctrl_seen = '0;
    int acc_cyc = -100;
    bit prev_valid = 0, prev_ready = 0, prev_err = 0;
    logic [W-1:0] prev_hi = '0, prev_lo = '0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!clr) begin
        exec_n = 0; ctrl_seen = '0; acc_cyc = -100; prev_valid = 0; prev_ready = 0;
      end else begin
        if (alu_ctrl != '0) begin
          exec_n++;
          ctrl_seen |= alu_ctrl;
        end
        if (prev_valid && prev_ready) begin
          chk("done_exit_valid", 64'(rsp_valid), 64'(0));
          chk("done_exit_ready", 64'(req_ready), 64'(1));
        end
        if (rsp_valid) begin
          chk("busy_req_ready", 64'(req_ready), 64'(0));
          if (!prev_valid) begin
            if (sb.size() == 0) begin
              checks++; errors++;
              $display("FAIL unexpected_rsp: got response, expected none (cycle %0d)", cyc);
            end else begin
              e = sb[0];
              chk("latency", 64'(cyc - acc_cyc), 64'(e.k + 1));
              chk("exec_len", 64'(exec_n), 64'(e.k));
              chk("alu_ctrl", 64'(ctrl_seen), 64'(e.ctrl));
            end
            exec_n = 0;
            ctrl_seen = '0;
          end else if (!prev_ready) begin
            chk("hold_hi", 64'(rsp_hi), 64'(prev_hi));
            chk("hold_lo", 64'(rsp_lo), 64'(prev_lo));
            chk("hold_err", 64'(rsp_err), 64'(prev_err));
          end
          if (rsp_ready && sb.size() > 0) begin
            e = sb.pop_front();
            chk("rsp_hi", 64'(rsp_hi), 64'(e.hi));
            chk("rsp_lo", 64'(rsp_lo), 64'(e.lo));
            chk("rsp_err", 64'(rsp_err), 64'(e.err));
          end
        end
        if (req_valid && req_ready) acc_cyc = cyc;
        prev_valid = rsp_valid; prev_ready = rsp_ready;
        prev_hi = rsp_hi; prev_lo = rsp_lo; prev_err = rsp_err;
      end
    end
  end

  task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int budget = 60;
    @(posedge clk); #1;
    req_valid = 1'b1; opcode = op; a_in = a; b_in = b;
    @(negedge clk);
    while (!req_ready && budget > 0) begin
      budget--;
      @(negedge clk);
    end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: req_ready stayed 0, expected 1");
    end else begin
      sb.push_back(ref_model(int'(op), a, b));
    end
    @(posedge clk); #1;
    req_valid = 1'b0; opcode = 4'($urandom); a_in = $urandom; b_in = $urandom;
  endtask

  task automatic drain();
    int budget = 300;
    while (sb.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    if (sb.size() > 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d responses outstanding, expected 0", sb.size());
      sb.delete();
    end
    repeat (2) @(posedge clk);
  endtask

  initial begin
    int budget;
    logic [3:0] op;
    logic [W-1:0] a, b;
    // Reset with a request and junk operands present.
    req_valid = 1'b1; opcode = 4'd2; a_in = 32'h1234_5678; b_in = 32'h9ABC_DEF0;
    repeat (3) @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("rst_alu_ctrl", 64'(alu_ctrl), 64'(0));
    chk("rst_alu_x", 64'(alu_x), 64'(0));
    chk("rst_alu_y", 64'(alu_y), 64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_rsp_hi", 64'(rsp_hi), 64'(0));
    chk("rst_rsp_lo", 64'(rsp_lo), 64'(0));
    chk("rst_rsp_err", 64'(rsp_err), 64'(0));
    @(posedge clk); #1;
    clr = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'(1));

    // Directed: add, mul, div by zero, bad opcode.
    rdy_mode = 1;
    send(4'd0, 32'd5, 32'd7);
    send(4'd2, 32'h0001_0000, 32'h0001_0000);
    send(4'd3, 32'd9, 32'd0);
    send(4'd13, 32'd1, 32'd2);
    drain();

    // Held response under backpressure.
    rdy_mode = 2;
    send(4'd9, 32'hF0F0_0000, 32'h0000_0F0F);
    budget = 20;
    while (!rsp_valid && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk("or_rsp_arrived", 64'(rsp_valid), 64'(1));
    repeat (5) begin
      @(negedge clk);
      chk("stall_req_ready", 64'(req_ready), 64'(0));
      chk("stall_rsp_valid", 64'(rsp_valid), 64'(1));
    end
    @(posedge clk);
    rdy_mode = 1;
    drain();

    // Reset during the second EXEC cycle of a multiply.
    send(4'd2, 32'd1000, 32'd3000);
    @(posedge clk); #1;
    chk("mid_mul_ctrl", 64'(alu_ctrl), 64'(12'h004));
    clr = 1'b0;
    @(posedge clk); #1;
    chk("abort_alu_ctrl", 64'(alu_ctrl), 64'(0));
    chk("abort_rsp_valid", 64'(rsp_valid), 64'(0));
    sb.delete();
    clr = 1'b1;
    @(posedge clk); #1;
    chk("abort_req_ready", 64'(req_ready), 64'(1));
    chk("abort_rsp_valid2", 64'(rsp_valid), 64'(0));
    send(4'd0, 32'hFFFF_FFFF, 32'd2);
    drain();

    // Random traffic with random backpressure.
    rdy_mode = 0;
    for (int i = 0; i < 80; i++) begin
      op = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(12, 15)) : 4'($urandom_range(0, 11));
      a = $urandom;
      b = ($urandom_range(0, 4) == 0) ? '0 : 32'($urandom);
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 40));
      send(op, a, b);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    rdy_mode = 1;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001: Parameter BITS, default 32, sets the operand and result width.
REQ-002: Parameter SIG_COUNT, default 12, sets the ALU one-hot control width.
REQ-003: Parameter MULDIV_CYCLES, default 4, sets the execute-phase length for multiply and divide (legal range 1..15).
REQ-004: clk  input  1  single clock; all state updates on its rising edge.
REQ-005: clr  input  1  reset; synchronous and active-low.
REQ-006: req_valid  input  1  a request is present.
REQ-007: req_ready  output  1  the sequencer accepts a request this cycle.
REQ-008: opcode  input  4  binary operation index 0..11 (add, sub, mul, div, shr, shl, ror, rol, and, or, neg, not).
REQ-009: a_in, b_in  input  BITS  operands, sampled on accept.
REQ-010: alu_ctrl  output  SIG_COUNT  one-hot control driven to the ALU.
REQ-011: alu_x, alu_y  output  BITS  registered operands driven to the ALU.
REQ-012: alu_hi, alu_lo  input  BITS  ALU result halves.
REQ-013: rsp_valid  output  1  a response is present.
REQ-014: rsp_ready  input  1  the consumer takes the response.
REQ-015: rsp_hi, rsp_lo  output  BITS  captured result.
REQ-016: rsp_err  output  1  the request was illegal (opcode > 11, or divide with b_in = 0).

Function
REQ-017: The FSM shall have exactly three states: IDLE, EXEC, DONE.
REQ-018: In IDLE, req_ready shall be 1; in EXEC and DONE it shall be 0.
REQ-019: On req_valid & req_ready, the sequencer shall register opcode, a_in and b_in, and drive them as alu_x = a, alu_y = b from the next cycle.
REQ-020: Illegal requests shall go IDLE->DONE directly, with rsp_err = 1, rsp_hi = rsp_lo = 0, and no cycle with alu_ctrl non-zero.
REQ-021: Legal requests shall go IDLE->EXEC; alu_ctrl shall be the one-hot encoding of the latched opcode throughout EXEC, and all-zero in every other state.
REQ-022: EXEC shall last 1 cycle for opcodes other than 2 and 3, and MULDIV_CYCLES cycles for opcodes 2 and 3, counted by an internal down-counter.
REQ-023: On the last EXEC cycle, the sequencer shall capture rsp_lo <= alu_lo; rsp_hi <= alu_hi for opcodes 2 and 3, and rsp_hi <= 0 otherwise (HI is undriven by the ALU for other operations).
REQ-024: In DONE, rsp_valid shall be 1 and rsp_hi, rsp_lo and rsp_err shall be held stable until rsp_ready = 1; then the FSM shall return to IDLE.
REQ-025: Latency shall be: request accepted at edge N gives rsp_valid high from edge N+1+k, where k is the EXEC length (0 for illegal requests).
REQ-026: Throughput shall be at most one request per k+2 cycles; there is no acceptance in the same cycle as the response handshake.
REQ-027: a_in, b_in and opcode changing while not accepted shall have no effect.
REQ-028: When rsp_ready is held high on DONE entry, the sequencer shall leave DONE after exactly one cycle.

Reset
REQ-029: With clr = 0 at a clock edge, state shall become IDLE and the counter 0.
REQ-030: With clr = 0 at a clock edge, alu_ctrl = 0, alu_x = alu_y = 0, rsp_valid = 0, rsp_hi = rsp_lo = 0, and rsp_err = 0.
REQ-031: An in-flight operation shall be discarded by reset (asserted in EXEC or DONE) and no response produced.
REQ-032: req_ready shall be 1 in the first cycle after clr returns high.

Structure
REQ-033: The shared package alu_seq_pkg shall hold the state enum, the opcode localparams OP_ADD..OP_NOT (0..11), OP_LAST = 11 and SIG_COUNT.
REQ-034: A single sub-module, op_onehot_decode (4-bit index -> SIG_COUNT one-hot, all-zero for indices > OP_LAST), shall generate alu_ctrl.

Verification
REQ-035: Add, opcode 0, a = 5, b = 7, with a model ALU -> alu_ctrl = 12'h001 for 1 cycle, rsp_lo = 12, rsp_hi = 0, rsp_valid at accept+2.
REQ-036: Mul, opcode 2, a = 32'h0001_0000, b = 32'h0001_0000 -> alu_ctrl = 12'h004 for 4 cycles, rsp_hi = 1, rsp_lo = 0, rsp_valid at accept+5.
REQ-037: Div, opcode 3, b = 0 -> no EXEC cycle, rsp_err = 1, rsp_hi = rsp_lo = 0 at accept+1; opcode 13 -> same response.
REQ-038: Or result ready, rsp_ready held low for 6 cycles -> rsp_* stable and req_ready = 0 throughout; IDLE one cycle after rsp_ready = 1.
REQ-039: clr = 0 during the 2nd EXEC cycle of a mul -> next cycle alu_ctrl = 0, rsp_valid = 0, and req_ready = 1 after release; a following add completes normally.
